// File: rtl/number_render_driver.sv
// Binary-to-BCD digit renderer for an on-screen decimal counter.
// Converts on request, commits at frame start, drives the font-ROM address/digit path.
module number_render_driver #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14,
  parameter int X0     = 0,
  parameter int Y0     = 0
) (
  input  logic             iClock,
  input  logic             iResetN,
  input  logic             iLoad,
  input  logic [BIN_W-1:0] iBinary,
  input  logic             iFrameStart,
  input  logic [9:0]       iX,
  input  logic [9:0]       iY,
  output logic             oBusy,
  output logic             oOverflow,
  output logic [10:0]      oAddress,
  output logic [3:0]       oValue,
  output logic             oInside
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int LIMIT = pow10(DIGITS);
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_FRAME
  } state_t;

  state_t state, stateNext;

  logic [BIN_W-1:0] shiftReg;
  logic [BW-1:0]    bcd;
  logic [BW-1:0]    bcdAdj;
  logic [BW-1:0]    bcdNext;
  logic [CW-1:0]    count;
  logic             ovfCapture;
  logic [BW-1:0]    pending;
  logic             pendingOvf;
  logic [BW-1:0]    display;
  logic [BW-1:0]    blanked;
  logic             leadZero;

  logic             accept;
  logic             shiftDone;
  logic             commit;

  assign accept    = (state == IDLE) && iLoad;
  assign shiftDone = (state == SHIFT) && (count == LAST);
  assign commit    = (state == WAIT_FRAME) && iFrameStart;
  assign oBusy     = (state != IDLE);

  always_ff @(posedge iClock) begin
    if (!iResetN) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:       if (iLoad)       stateNext = SHIFT;
      SHIFT:      if (shiftDone)   stateNext = WAIT_FRAME;
      WAIT_FRAME: if (iFrameStart) stateNext = IDLE;
      default:                     stateNext = IDLE;
    endcase
  end

  // Add-3 correction, then shift the next binary MSB into the BCD LSB.
  always_comb begin
    bcdAdj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcdAdj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcdNext = (bcdAdj << 1) | BW'(shiftReg[BIN_W-1]);
  end

  // Zeros above the highest non-zero digit become blanks; digit 0 never does.
  always_comb begin
    blanked  = pending;
    leadZero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (leadZero && pending[4*i +: 4] == 4'd0)
        blanked[4*i +: 4] = 4'hF;
      else
        leadZero = 1'b0;
    end
  end

  always_ff @(posedge iClock) begin
    if (!iResetN) begin
      shiftReg     <= '0;
      bcd          <= '0;
      count        <= '0;
      ovfCapture   <= 1'b0;
      pending      <= '0;
      pendingOvf   <= 1'b0;
      display      <= '1;
      display[3:0] <= 4'h0;
      oOverflow    <= 1'b0;
    end else begin
      if (accept) begin
        shiftReg   <= iBinary;
        bcd        <= '0;
        count      <= '0;
        ovfCapture <= (32'(iBinary) >= 32'(LIMIT));
      end
      if (state == SHIFT) begin
        shiftReg <= shiftReg << 1;
        bcd      <= bcdNext;
        count    <= count + CW'(1);
      end
      if (shiftDone) begin
        pending    <= ovfCapture ? {DIGITS{4'h9}} : bcdNext;
        pendingOvf <= ovfCapture;
      end
      if (commit) begin
        display   <= blanked;
        oOverflow <= pendingOvf;
      end
    end
  end

  logic [9:0] col;
  logic [5:0] row;
  logic [4:0] pos;
  logic       insideNow;
  logic       insideD1;
  logic [3:0] digitSel;

  assign col = iX - 10'(X0);
  assign row = iY[5:0] - 6'(Y0);
  assign pos = col[9:5];

  assign insideNow = (int'(iX) >= X0) && (int'(iX) < X0 + 32 * DIGITS) &&
                     (int'(iY) >= Y0) && (int'(iY) < Y0 + 64);

  // Position 0 is the leftmost, most significant digit.
  always_comb begin
    digitSel = 4'hF;
    for (int i = 0; i < DIGITS; i++) begin
      if (pos == 5'(i))
        digitSel = display[4*(DIGITS-1-i) +: 4];
    end
  end

  always_ff @(posedge iClock) begin
    if (!iResetN) begin
      oAddress <= '0;
      oValue   <= 4'hF;
      insideD1 <= 1'b0;
      oInside  <= 1'b0;
    end else begin
      oAddress <= insideNow ? {row, col[4:0]} : 11'd0;
      oValue   <= insideNow ? digitSel : 4'hF;
      insideD1 <= insideNow;
      oInside  <= insideD1;
    end
  end

endmodule

// File: tb/tb_number_render_driver.sv
// Scoreboard bench for number_render_driver.
// Stimulus queues expected values by cycle; a monitor compares them.
module tb_number_render_driver;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int X0     = 64;
  localparam int Y0     = 32;

  localparam int K_VAL  = 0;
  localparam int K_ADDR = 1;
  localparam int K_IN   = 2;
  localparam int K_BUSY = 3;
  localparam int K_OVF  = 4;

  logic             iClock = 1'b0;
  logic             iResetN = 1'b0;
  logic             iLoad = 1'b0;
  logic [BIN_W-1:0] iBinary = '0;
  logic             iFrameStart = 1'b0;
  logic [9:0]       iX = '0;
  logic [9:0]       iY = '0;
  logic             oBusy;
  logic             oOverflow;
  logic [10:0]      oAddress;
  logic [3:0]       oValue;
  logic             oInside;

  number_render_driver #(
    .DIGITS(DIGITS),
    .BIN_W (BIN_W),
    .X0    (X0),
    .Y0    (Y0)
  ) dut (
    .iClock     (iClock),
    .iResetN    (iResetN),
    .iLoad      (iLoad),
    .iBinary    (iBinary),
    .iFrameStart(iFrameStart),
    .iX         (iX),
    .iY         (iY),
    .oBusy      (oBusy),
    .oOverflow  (oOverflow),
    .oAddress   (oAddress),
    .oValue     (oValue),
    .oInside    (oInside)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    int    cyc;
    int    kind;
    int    exp;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   act;

  always @(posedge iClock) cycle++;

  always @(posedge iClock) begin
    #1;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cycle) begin
        case (sb[i].kind)
          K_VAL:   act = int'(oValue);
          K_ADDR:  act = int'(oAddress);
          K_IN:    act = int'(oInside);
          K_BUSY:  act = int'(oBusy);
          default: act = int'(oOverflow);
        endcase
        vectors++;
        if (sb[i].cyc < cycle || act != sb[i].exp) begin
          miscompares++;
          $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                   sb[i].name, act, sb[i].exp, cycle);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge iClock);
  endtask

  task automatic expectAt(input int lat, input int kind, input int exp,
                          input string name);
    exp_t e;
    e.cyc  = cycle + lat;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic pix(input int x, input int y, input int v, input int a,
                     input int ins, input string name);
    iX = 10'(x);
    iY = 10'(y);
    expectAt(1, K_VAL, v, {name, ".value"});
    expectAt(1, K_ADDR, a, {name, ".addr"});
    expectAt(2, K_IN, ins, {name, ".inside"});
    tick(1);
  endtask

  task automatic showDigits(input int d0, input int d1, input int d2,
                            input int d3, input string name);
    pix(X0 + 5,      Y0 + 10, d0, 325, 1, {name, ".p0"});
    pix(X0 + 32 + 5, Y0 + 10, d1, 325, 1, {name, ".p1"});
    pix(X0 + 64 + 5, Y0 + 10, d2, 325, 1, {name, ".p2"});
    pix(X0 + 96 + 5, Y0 + 10, d3, 325, 1, {name, ".p3"});
  endtask

  task automatic load(input int v, input logic fs, input int prevOvf,
                      input string name);
    iLoad = 1'b1;
    iBinary = BIN_W'(v);
    iFrameStart = fs;
    expectAt(1, K_BUSY, 1, {name, ".busyRise"});
    expectAt(BIN_W + 1, K_BUSY, 1, {name, ".busyHold"});
    expectAt(BIN_W + 1, K_OVF, prevOvf, {name, ".ovfBefore"});
    tick(1);
    iLoad = 1'b0;
    iFrameStart = 1'b0;
    tick(BIN_W + 1);
  endtask

  task automatic commit(input int ovf, input string name);
    iFrameStart = 1'b1;
    expectAt(1, K_BUSY, 0, {name, ".busyFall"});
    expectAt(1, K_OVF, ovf, {name, ".ovf"});
    tick(1);
    iFrameStart = 1'b0;
    vectors++;
    if (oOverflow !== 1'(ovf)) begin
      miscompares++;
      $display("FAIL %s.ovfDirect: got %0b expected %0d", name, oOverflow, ovf);
    end
    vectors++;
    if (oBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s.busyDirect: got %0b expected 0", name, oBusy);
    end
    tick(1);
  endtask

  initial begin
    iX = 10'd1000;
    iY = 10'd1000;
    tick(2);
    iX = 10'(X0);
    iY = 10'(Y0);
    expectAt(1, K_BUSY, 0, "rst.busy");
    expectAt(1, K_OVF, 0, "rst.ovf");
    expectAt(1, K_VAL, 15, "rst.value");
    expectAt(1, K_ADDR, 0, "rst.addr");
    expectAt(1, K_IN, 0, "rst.inside");
    tick(1);
    iResetN = 1'b1;
    tick(1);
    showDigits(15, 15, 15, 0, "rstDisp");

    load(1234, 1'b0, 0, "l1234");
    commit(0, "c1234");
    pix(X0,      Y0,      1, 0,    1, "d1234.p0");
    pix(X0 + 32, Y0,      2, 0,    1, "d1234.p1");
    pix(X0 + 96, Y0 + 63, 4, 2016, 1, "d1234.p3bot");

    pix(X0 + 127, Y0,      4,  31, 1, "scan.x127");
    pix(X0 + 128, Y0,      15, 0,  0, "scan.x128");
    pix(X0 + 5,   Y0 + 64, 15, 0,  0, "scan.y64");
    pix(X0 - 1,   Y0,      15, 0,  0, "scan.xm1");
    pix(X0 + 64,  Y0 + 1,  3,  32, 1, "scan.row1");
    pix(X0,       Y0 - 1,  15, 0,  0, "scan.ym1");

    load(7, 1'b1, 0, "l7");
    commit(0, "c7");
    showDigits(15, 15, 15, 7, "d7");

    load(0, 1'b0, 0, "l0");
    commit(0, "c0");
    showDigits(15, 15, 15, 0, "d0");

    load(1000, 1'b0, 0, "l1000");
    commit(0, "c1000");
    showDigits(1, 0, 0, 0, "d1000");

    load(9999, 1'b0, 0, "l9999");
    commit(0, "c9999");
    showDigits(9, 9, 9, 9, "d9999");

    load(12000, 1'b0, 0, "l12000");
    commit(1, "c12000");
    showDigits(9, 9, 9, 9, "d12000");

    load(42, 1'b0, 1, "l42");
    commit(0, "c42");
    showDigits(15, 15, 4, 2, "d42");

    iLoad = 1'b1;
    iBinary = BIN_W'(55);
    tick(1);
    iLoad = 1'b0;
    tick(3);
    iLoad = 1'b1;
    iBinary = BIN_W'(99);
    iFrameStart = 1'b1;
    tick(1);
    iLoad = 1'b0;
    iFrameStart = 1'b0;
    tick(BIN_W);
    iLoad = 1'b1;
    expectAt(1, K_BUSY, 1, "l55.waitBusy");
    tick(1);
    iLoad = 1'b0;
    commit(0, "c55");
    showDigits(15, 15, 5, 5, "d55");

    iLoad = 1'b1;
    iBinary = BIN_W'(77);
    tick(1);
    iLoad = 1'b0;
    tick(4);
    iResetN = 1'b0;
    expectAt(1, K_BUSY, 0, "midRst.busy");
    expectAt(1, K_OVF, 0, "midRst.ovf");
    tick(1);
    iResetN = 1'b1;
    tick(BIN_W + 2);
    for (int k = 0; k < 3; k++) begin
      iFrameStart = 1'b1;
      expectAt(1, K_BUSY, 0, "midRst.frameBusy");
      tick(1);
      iFrameStart = 1'b0;
      tick(2);
    end
    showDigits(15, 15, 15, 0, "midRstDisp");

    tick(4);
    vectors++;
    if (oBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL end.busy: got %0b expected 0", oBusy);
    end
    vectors++;
    if (oOverflow !== 1'b0) begin
      miscompares++;
      $display("FAIL end.ovf: got %0b expected 0", oOverflow);
    end
    vectors++;
    if (oInside !== 1'b1) begin
      miscompares++;
      $display("FAIL end.inside: got %0b expected 1", oInside);
    end
    while (sb.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: never checked (due cycle %0d)", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
